// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the TPU job arbiter
package tpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } arb_state_t;

    localparam int OPERAND_BYTES          = 8;
    localparam int RESULT_BYTES           = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = valid[prio] ? prio : ~prio;
        grant     = 2'b00;
        if (valid[grant_idx]) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/tpu_job_arbiter.sv
// rtl/tpu_job_arbiter.sv - two-requester job scheduler for the 2x2 TPU core
module tpu_job_arbiter
    import tpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_data,
    input  logic [3:0]  req_cfg,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        tpu_load_en,
    output logic [7:0]  tpu_data,
    output logic        tpu_transpose,
    output logic        tpu_activation,
    input  logic [7:0]  tpu_out,
    input  logic        tpu_done,
    output logic        busy,
    output logic        owner
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int BC_W = $clog2(OPERAND_BYTES);
    localparam int RI_W = $clog2(RESULT_BYTES);

    arb_state_t      state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic            cfg_t_q, cfg_t_d;
    logic            cfg_a_q, cfg_a_d;
    logic            err_q, err_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [RI_W-1:0] cap_idx_q, cap_idx_d;
    logic [RI_W-1:0] rsp_idx_q, rsp_idx_d;
    logic [7:0]      res_buf_q [RESULT_BYTES];
    logic [7:0]      res_buf_d [RESULT_BYTES];
    logic            load_en_q, load_en_d;
    logic [7:0]      tdata_q, tdata_d;

    logic [1:0]      grant;
    logic            grant_idx;
    logic [7:0]      owner_byte;
    logic            load_hs;
    logic            rsp_hs;
    logic            in_job;

    rr_arbiter2 u_rr (
        .valid     (req_valid),
        .prio      (prio_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign owner_byte = owner_q ? req_data[15:8] : req_data[7:0];
    assign load_hs    = (state_q == ST_LOAD) && req_valid[owner_q];
    assign rsp_hs     = (state_q == ST_RESP) && rsp_ready[owner_q];
    assign in_job     = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        cfg_t_d    = cfg_t_q;
        cfg_a_d    = cfg_a_q;
        err_d      = err_q;
        byte_cnt_d = byte_cnt_q;
        wd_d       = wd_q;
        cap_idx_d  = cap_idx_q;
        rsp_idx_d  = rsp_idx_q;
        res_buf_d  = res_buf_q;
        load_en_d  = 1'b0;
        tdata_d    = tdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d    = grant_idx;
                    cfg_t_d    = req_cfg[{grant_idx, 1'b1}];
                    cfg_a_d    = req_cfg[{grant_idx, 1'b0}];
                    byte_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_hs) begin
                    tdata_d    = owner_byte;
                    load_en_d  = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == BC_W'(OPERAND_BYTES - 1)) begin
                        wd_d    = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                // done outranks a coincident timeout
                if (tpu_done) begin
                    res_buf_d[0] = tpu_out;
                    cap_idx_d    = RI_W'(1);
                    state_d      = ST_CAPTURE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    for (int i = 0; i < RESULT_BYTES; i++) begin
                        res_buf_d[i] = 8'h00;
                    end
                    err_d     = 1'b1;
                    rsp_idx_d = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                res_buf_d[cap_idx_q] = tpu_out;
                cap_idx_d            = cap_idx_q + 1'b1;
                if (cap_idx_q == RI_W'(RESULT_BYTES - 1)) begin
                    rsp_idx_d = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_idx_d = rsp_idx_q + 1'b1;
                    if (rsp_idx_q == RI_W'(RESULT_BYTES - 1)) begin
                        prio_d  = ~owner_q;
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            cfg_t_q    <= 1'b0;
            cfg_a_q    <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            wd_q       <= '0;
            cap_idx_q  <= '0;
            rsp_idx_q  <= '0;
            load_en_q  <= 1'b0;
            tdata_q    <= 8'h00;
            for (int i = 0; i < RESULT_BYTES; i++) begin
                res_buf_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            cfg_t_q    <= cfg_t_d;
            cfg_a_q    <= cfg_a_d;
            err_q      <= err_d;
            byte_cnt_q <= byte_cnt_d;
            wd_q       <= wd_d;
            cap_idx_q  <= cap_idx_d;
            rsp_idx_q  <= rsp_idx_d;
            load_en_q  <= load_en_d;
            tdata_q    <= tdata_d;
            for (int i = 0; i < RESULT_BYTES; i++) begin
                res_buf_q[i] <= res_buf_d[i];
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = 8'h00;
        rsp_err   = 1'b0;
        rsp_last  = 1'b0;
        if (state_q == ST_LOAD) begin
            req_ready = owner_q ? 2'b10 : 2'b01;
        end
        if (state_q == ST_RESP) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
            rsp_data  = res_buf_q[rsp_idx_q];
            rsp_err   = err_q;
            rsp_last  = (rsp_idx_q == RI_W'(RESULT_BYTES - 1));
        end
    end

    assign tpu_load_en    = load_en_q;
    assign tpu_data       = tdata_q;
    assign tpu_transpose  = cfg_t_q & in_job;
    assign tpu_activation = cfg_a_q & in_job;
    assign busy           = (state_q != ST_IDLE);
    assign owner          = owner_q;

endmodule

// File: tb/tb_tpu_job_arbiter.sv
// tb/tb_tpu_job_arbiter.sv - scoreboard bench for tpu_job_arbiter
module tb_tpu_job_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_cfg;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic        tpu_load_en;
    logic [7:0]  tpu_data;
    logic        tpu_transpose;
    logic        tpu_activation;
    logic [7:0]  tpu_out;
    logic        tpu_done;
    logic        busy;
    logic        owner;

    always #5 clk = ~clk;

    tpu_job_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_cfg        (req_cfg),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_last       (rsp_last),
        .tpu_load_en    (tpu_load_en),
        .tpu_data       (tpu_data),
        .tpu_transpose  (tpu_transpose),
        .tpu_activation (tpu_activation),
        .tpu_out        (tpu_out),
        .tpu_done       (tpu_done),
        .busy           (busy),
        .owner          (owner)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {owner, transpose, activation, byte}
    logic [10:0] load_q [$];
    // {last, err, data}
    logic [9:0]  rsp_q0 [$];
    logic [9:0]  rsp_q1 [$];

    bit          core_hang  = 1'b0;
    bit          stall_mode = 1'b0;
    int          stall_ph   = 0;
    int          served     = 0;
    int          load8_cyc  = 0;
    int          core_cnt   = 0;

    function automatic logic [7:0] core_result(input logic [7:0] ops [8], input int j);
        logic [7:0] m;
        m = 8'(32'h11 * (j + 1));
        return m ^ (ops[0] - 8'd1) ^ ops[7] ^ 8'h08;
    endfunction

    function automatic logic [26:0] all_outputs();
        return {req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, tpu_load_en,
                tpu_data, tpu_transpose, tpu_activation, busy, owner};
    endfunction

    // Core model: collects 8 loads, then raises done and streams 4 result bytes.
    initial begin
        logic [7:0]  ops [8];
        logic [10:0] e;
        int          done_in;
        int          cap_k;
        logic        cur_t;
        done_in  = -1;
        cap_k    = 0;
        cur_t    = 1'b0;
        tpu_done = 1'b0;
        tpu_out  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            tpu_done = 1'b0;
            tpu_out  = 8'h00;
            if (rst) begin
                done_in = -1;
                cap_k   = 0;
            end
            if (cap_k > 0) begin
                tpu_out = core_result(ops, cap_k);
                check_eq("cap_transpose", tpu_transpose, cur_t);
                cap_k = (cap_k == 3) ? 0 : cap_k + 1;
            end else if (done_in == 0) begin
                tpu_done = 1'b1;
                tpu_out  = core_result(ops, 0);
                check_eq("done_transpose", tpu_transpose, cur_t);
                cap_k   = 1;
                done_in = -1;
            end else if (done_in > 0) begin
                done_in--;
            end
            if (tpu_load_en === 1'b1) begin
                if (load_q.size() == 0) begin
                    check_eq("load_unexpected", 1, 0);
                end else begin
                    e = load_q.pop_front();
                    check_eq("load_data", tpu_data, e[7:0]);
                    check_eq("load_transpose", tpu_transpose, e[9]);
                    check_eq("load_activation", tpu_activation, e[8]);
                    check_eq("load_owner", owner, e[10]);
                    ops[core_cnt] = tpu_data;
                    cur_t = e[9];
                    core_cnt++;
                    if (core_cnt == 8) begin
                        core_cnt  = 0;
                        load8_cyc = cyc;
                        if (!core_hang) done_in = 5;
                    end
                end
            end
        end
    end

    // Response monitor and rsp_ready driver.
    initial begin
        logic [3:0] pat;
        logic [9:0] e;
        logic       id;
        logic       held_v;
        logic [7:0] held_d;
        bit         in_rsp;
        pat       = 4'b1001;
        held_v    = 1'b0;
        held_d    = 8'h00;
        in_rsp    = 1'b0;
        rsp_ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = stall_mode ? {2{pat[stall_ph[1:0]]}} : 2'b11;
            #1;
            if (rsp_valid != 2'b00) begin
                id = rsp_valid[1];
                check_eq("rsp_valid_onehot", $countones(rsp_valid), 1);
                check_eq("rsp_cfg_idle", {tpu_transpose, tpu_activation}, 2'b00);
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (core_hang) check_eq("timeout_latency", cyc - load8_cyc, TMO);
                end
                if (held_v) check_eq("rsp_hold", rsp_data, held_d);
                if (rsp_ready[id]) begin
                    held_v = 1'b0;
                    if ((id ? rsp_q1.size() : rsp_q0.size()) == 0) begin
                        check_eq("rsp_unexpected", 1, 0);
                    end else begin
                        e = id ? rsp_q1.pop_front() : rsp_q0.pop_front();
                        check_eq("rsp_data", rsp_data, e[7:0]);
                        check_eq("rsp_err", rsp_err, e[8]);
                        check_eq("rsp_last", rsp_last, e[9]);
                    end
                    if (rsp_last) begin
                        served = served * 4 + int'(id) + 1;
                        in_rsp = 1'b0;
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = rsp_data;
                end
                if (stall_mode) stall_ph++;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic run_req(input int idx, input logic [7:0] base, input logic [1:0] cfg,
                           input int gap_after, input int gap_len, input int stop_after);
        logic [7:0] ops [8];
        logic       id;
        int         w;
        id = idx[0];
        for (int k = 0; k < 8; k++) ops[k] = base + 8'(k);
        if (id) req_cfg[3:2] = cfg; else req_cfg[1:0] = cfg;
        if (stop_after == 8) begin
            for (int j = 0; j < 4; j++) begin
                if (id) rsp_q1.push_back({j == 3, core_hang, core_hang ? 8'h00 : core_result(ops, j)});
                else    rsp_q0.push_back({j == 3, core_hang, core_hang ? 8'h00 : core_result(ops, j)});
            end
        end
        for (int k = 0; k < stop_after; k++) begin
            if (k == gap_after && gap_len > 0) begin
                req_valid[id] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            if (id) req_data[15:8] = ops[k]; else req_data[7:0] = ops[k];
            req_valid[id] = 1'b1;
            w = 0;
            while (!req_ready[id] && w < 400) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (w >= 400) begin
                check_eq("grant_timeout", 0, 1);
                req_valid[id] = 1'b0;
                return;
            end
            check_eq("other_ready_low", req_ready[~id], 1'b0);
            load_q.push_back({id, cfg, ops[k]});
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_quiet();
        int w;
        w = 0;
        while ((rsp_q0.size() != 0 || rsp_q1.size() != 0 || busy) && w < 600) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("job_complete", w < 600, 1);
        check_eq("load_q_empty", load_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_cfg   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outputs(), 27'd0);
        rst = 1'b0;

        // both requesters contend from reset: 0, 1, 0
        served = 0;
        fork
            begin
                run_req(0, 8'h01, 2'b00, 8, 0, 8);
                run_req(0, 8'h31, 2'b01, 8, 0, 8);
            end
            run_req(1, 8'h21, 2'b00, 8, 0, 8);
        join
        wait_quiet();
        check_eq("served_order_010", served, 25);

        // single requester 0, bytes 1..8 -> 11 22 33 44
        served = 0;
        run_req(0, 8'h01, 2'b00, 8, 0, 8);
        wait_quiet();
        check_eq("served_single0", served, 1);

        // requester 1 with transpose and a 3-cycle gap after byte 4
        served = 0;
        run_req(1, 8'h41, 2'b10, 4, 3, 8);
        wait_quiet();
        check_eq("served_gap1", served, 2);

        // response back-pressure 1,0,0,1
        stall_mode = 1'b1;
        stall_ph   = 0;
        run_req(0, 8'h91, 2'b01, 8, 0, 8);
        wait_quiet();
        stall_mode = 1'b0;

        // watchdog timeout, then both valid: prio flipped to requester 1
        core_hang = 1'b1;
        run_req(0, 8'h51, 2'b11, 8, 0, 8);
        wait_quiet();
        core_hang = 1'b0;
        served = 0;
        fork
            run_req(0, 8'h61, 2'b00, 8, 0, 8);
            run_req(1, 8'hA1, 2'b01, 8, 0, 8);
        join
        wait_quiet();
        check_eq("served_after_timeout", served, 9);

        // reset mid-load, then a clean requester-1 job
        served = 0;
        run_req(0, 8'h71, 2'b11, 8, 0, 5);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midload_reset_outputs", all_outputs(), 27'd0);
        rst = 1'b0;
        load_q.delete();
        core_cnt = 0;
        run_req(1, 8'h81, 2'b11, 8, 0, 8);
        wait_quiet();
        check_eq("served_post_reset", served, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
